// File: rtl/sr_latch_access_arbiter.sv
// rtl/sr_latch_access_arbiter.sv - round-robin arbiter sequencing one gated SR latch
// Setup/gate/hold/readback sequencing with all outputs registered.
module sr_latch_access_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int CHK_TIMEOUT = 4,
    parameter int OW          = $clog2(N_REQ)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_set,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic             err,
    output logic             busy,
    output logic [OW-1:0]    owner,
    output logic             latch_S,
    output logic             latch_R,
    output logic             latch_en,
    input  logic             latch_Qa,
    input  logic             latch_Qb
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        PULSE   = 3'd2,
        RELEASE = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             target_q, target_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic [3:0]       chk_cnt_q, chk_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             latch_s_q, latch_s_d;
    logic             latch_r_q, latch_r_d;
    logic             latch_en_q, latch_en_d;

    logic [1:0]       rst_sync_q;
    logic             rst_n_s;
    logic             found;
    logic [OW-1:0]    win;
    logic [OW-1:0]    cand;
    int               base;
    logic             drive_sr;
    logic             readback_ok;

    // Assertion is immediate; release is retimed through two flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        base  = (int'(ptr_q) < N_REQ) ? int'(ptr_q) : 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = OW'((base + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign readback_ok = (latch_Qa == target_q) && (latch_Qb == !target_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        target_d   = target_q;
        hold_cnt_d = hold_cnt_q;
        chk_cnt_d  = chk_cnt_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d  = win;
                    target_d = req_set[win];
                    ptr_d    = OW'((int'(win) + 1) % N_REQ);
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                hold_cnt_d = '0;
                state_d    = PULSE;
            end
            PULSE: begin
                if (hold_cnt_q == 4'(HOLD_CYCLES - 1)) begin
                    state_d = RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            RELEASE: begin
                chk_cnt_d = '0;
                state_d   = CHECK;
            end
            CHECK: begin
                if (readback_ok) begin
                    state_d = DONE;
                end else if (chk_cnt_q == 4'(CHK_TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    chk_cnt_d = chk_cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so they register in step with it.
        busy_d   = (state_d != IDLE);
        grant_d  = '0;
        done_d   = '0;
        if (busy_d) begin
            grant_d[owner_d] = 1'b1;
        end
        if (state_d == DONE) begin
            done_d[owner_d] = 1'b1;
        end
        drive_sr   = (state_d == SETUP) || (state_d == PULSE) || (state_d == RELEASE);
        latch_s_d  = drive_sr & target_d;
        latch_r_d  = drive_sr & ~target_d;
        latch_en_d = (state_d == PULSE);
    end

    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            target_q   <= 1'b0;
            hold_cnt_q <= '0;
            chk_cnt_q  <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            latch_s_q  <= 1'b0;
            latch_r_q  <= 1'b0;
            latch_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            target_q   <= target_d;
            hold_cnt_q <= hold_cnt_d;
            chk_cnt_q  <= chk_cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            latch_s_q  <= latch_s_d;
            latch_r_q  <= latch_r_d;
            latch_en_q <= latch_en_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign latch_S  = latch_s_q;
    assign latch_R  = latch_r_q;
    assign latch_en = latch_en_q;

endmodule

// File: tb/tb_sr_latch_access_arbiter.sv
// tb/tb_sr_latch_access_arbiter.sv - scoreboard bench for sr_latch_access_arbiter
module tb_sr_latch_access_arbiter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] req_set = 4'b0000;
    logic [3:0] grant, done;
    logic       err, busy;
    logic [1:0] owner;
    logic       latch_S, latch_R, latch_en;
    logic       latch_Qa, latch_Qb;

    logic       lq = 1'b0;
    logic       stuck = 1'b0;
    int         errors = 0;
    int         checks = 0;

    logic       prev_en = 1'b0, prev_s = 1'b0, prev_r = 1'b0;
    logic       saw_r;
    int         chk_cyc;
    int         done_at;

    typedef struct packed {
        logic [3:0] done;
        logic       err;
        logic [1:0] owner;
    } exp_t;
    exp_t sb_q[$];

    sr_latch_access_arbiter #(
        .N_REQ(4), .HOLD_CYCLES(2), .CHK_TIMEOUT(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_set(req_set),
        .grant(grant), .done(done), .err(err), .busy(busy), .owner(owner),
        .latch_S(latch_S), .latch_R(latch_R), .latch_en(latch_en),
        .latch_Qa(latch_Qa), .latch_Qb(latch_Qb)
    );

    always #5 clock = ~clock;

    assign latch_Qa = stuck ? 1'b0 : lq;
    assign latch_Qb = stuck ? 1'b1 : ~lq;

    always @(posedge clock) begin
        if (latch_en) begin
            if (latch_S) lq <= 1'b1;
            else if (latch_R) lq <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] d, input logic e, input logic [1:0] o);
        exp_t x;
        x.done  = d;
        x.err   = e;
        x.owner = o;
        sb_q.push_back(x);
    endtask

    always @(negedge clock) begin
        exp_t x;
        chk("s_and_r", 32'(latch_S & latch_R), 0);
        chk("grant_onehot0", 32'($onehot0(grant)), 1);
        chk("done_in_grant", 32'(done & ~grant), 0);
        if (latch_en && prev_en) chk("sr_stable_gate", {latch_S, latch_R}, {prev_s, prev_r});
        if (err && done == 4'b0000) chk("err_without_done", 32'(err), 0);
        if (done != 4'b0000) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 32'(done), 0);
            end else begin
                x = sb_q.pop_front();
                chk("sb_done", 32'(done), 32'(x.done));
                chk("sb_err", 32'(err), 32'(x.err));
                chk("sb_owner", 32'(owner), 32'(x.owner));
            end
        end
        prev_en = latch_en;
        prev_s  = latch_S;
        prev_r  = latch_R;
    end

    // Requesters drop their req after their own done pulse.
    task automatic run_to_idle(input int max_cyc);
        int n;
        n       = 0;
        saw_r   = 1'b0;
        chk_cyc = 0;
        done_at = -1;
        do begin
            @(negedge clock);
            n++;
            if (latch_en && latch_R) saw_r = 1'b1;
            if (busy && grant != 4'b0000 && !latch_S && !latch_R && !latch_en && done == 4'b0000)
                chk_cyc++;
            if (done != 4'b0000 && done_at < 0) done_at = n;
            req = req & ~done;
        end while (!(req == 4'b0000 && !busy) && n < max_cyc);
        if (n >= max_cyc) chk("run_timeout", 1, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        int n;

        // 1: reset with random requests
        reset_n = 1'b0;
        req     = 4'($urandom_range(1, 15));
        req_set = 4'($urandom);
        repeat (3) @(negedge clock);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_sre", {latch_S, latch_R, latch_en}, 0);
        req = 4'b0000;
        req_set = 4'b0000;
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clock);
            chk("idle_busy", 32'(busy), 0);
        end

        // 2: single set, exact cycle timing; req_set change mid-op is ignored
        push_exp(4'b0001, 1'b0, 2'd0);
        req_set = 4'b0001;
        req     = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (k == 2) req_set = 4'b0000;
            case (k)
                1: begin
                    chk("s2_setup_grant", 32'(grant), 32'h1);
                    chk("s2_setup_busy", 32'(busy), 1);
                    chk("s2_setup_sre", {latch_S, latch_R, latch_en}, 3'b100);
                end
                2, 3: chk("s2_pulse_sre", {latch_S, latch_R, latch_en}, 3'b101);
                4: chk("s2_release_sre", {latch_S, latch_R, latch_en}, 3'b100);
                5: begin
                    chk("s2_check_sre", {latch_S, latch_R, latch_en}, 3'b000);
                    chk("s2_check_nodone", 32'(done), 0);
                end
                6: begin
                    chk("s2_done", 32'(done), 32'h1);
                    chk("s2_err", 32'(err), 0);
                    req = 4'b0000;
                end
                default: begin
                    chk("s2_idle_busy", 32'(busy), 0);
                    chk("s2_idle_grant", 32'(grant), 0);
                end
            endcase
        end
        chk("s2_qa", 32'(latch_Qa), 1);
        chk("s2_qb", 32'(latch_Qb), 0);

        // 3: clear after set
        push_exp(4'b0100, 1'b0, 2'd2);
        req_set = 4'b0000;
        req     = 4'b0100;
        run_to_idle(60);
        chk("s3_saw_r", 32'(saw_r), 1);
        chk("s3_owner", 32'(owner), 2);
        chk("s3_qa", 32'(latch_Qa), 0);
        chk("s3_qb", 32'(latch_Qb), 1);

        // 4: contention from pointer 0
        pulse_reset();
        push_exp(4'b0001, 1'b0, 2'd0);
        push_exp(4'b0010, 1'b0, 2'd1);
        push_exp(4'b1000, 1'b0, 2'd3);
        req_set = 4'($urandom);
        req     = 4'b1011;
        run_to_idle(200);
        push_exp(4'b0001, 1'b0, 2'd0);
        push_exp(4'b0010, 1'b0, 2'd1);
        push_exp(4'b0100, 1'b0, 2'd2);
        push_exp(4'b1000, 1'b0, 2'd3);
        req_set = 4'($urandom);
        req     = 4'b1111;
        run_to_idle(200);

        // 5: stuck readback times out
        stuck = 1'b1;
        push_exp(4'b0001, 1'b1, 2'd0);
        req_set = 4'b1111;
        req     = 4'b0001;
        run_to_idle(60);
        chk("s5_check_cycles", 32'(chk_cyc), 4);
        chk("s5_done_cycle", 32'(done_at), 9);
        stuck = 1'b0;

        // 6: reset during the gate pulse
        req_set = 4'b0010;
        req     = 4'b0010;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!latch_en && n < 20);
        chk("s6_saw_en", 32'(latch_en), 1);
        reset_n = 1'b0;
        #1;
        chk("s6_en", 32'(latch_en), 0);
        chk("s6_s", 32'(latch_S), 0);
        chk("s6_grant", 32'(grant), 0);
        chk("s6_busy", 32'(busy), 0);
        chk("s6_done", 32'(done), 0);
        chk("s6_owner", 32'(owner), 0);
        repeat (2) @(negedge clock);
        req = 4'b0000;
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        push_exp(4'b0001, 1'b0, 2'd0);
        push_exp(4'b0010, 1'b0, 2'd1);
        push_exp(4'b0100, 1'b0, 2'd2);
        push_exp(4'b1000, 1'b0, 2'd3);
        req_set = 4'($urandom);
        req     = 4'b1111;
        run_to_idle(200);

        chk("sb_left", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
